// File: rtl/uart_tx.sv
// UART transmitter: small write FIFO feeding a start/data/stop serialiser paced by a 16x baud_tick.
// The line output is registered and idles high; frames go out LSB first.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  output logic                 empty,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int STOP_W = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int TICK_W = (STOP_W > 4) ? STOP_W : 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push, pop;

  logic [1:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign push         = wr_en && !full;
  assign pop          = (state_q == S_IDLE) && !empty;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done_tick = done_q;
  assign overflow     = ovf_q;

  // full is the pre-edge value, so a write into a full FIFO is dropped even when a pop frees a slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = wr_en && full;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q];
          tick_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_W'(15)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_W'(15)) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = S_STOP;
            else                                bit_d   = bit_q + BIT_W'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: begin
        if (baud_tick) begin
          if (tick_q == TICK_W'(STOP_TICKS - 1)) begin
            tick_d  = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
    endcase
    // Line level is registered from the next state so tx moves on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_tx;

  localparam int DEPTH = 4;
  localparam int FRAME = 16 * (1 + 8) + 16;

  logic       clk = 1'b0, reset = 1'b0, baud_tick = 1'b0, wr_en = 1'b0, wr_en2 = 1'b0;
  logic [7:0] din = 8'h00, din2 = 8'h00;
  logic       full, empty, tx, tx_busy, tx_done_tick, overflow;
  logic       full2, empty2, tx2, tx_busy2, tx_done_tick2, overflow2;

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, done2_cnt = 0, tick_cnt = 0;
  int d0, n, tot, ones, zeros;
  bit seen;

  // frame-level model
  logic [7:0] m_q[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_busy = 0, m_done = 0, m_ovf = 0, pop_now, full_pre;
  int         m_ticks = 0;

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .STOP_TICKS(16)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .wr_en(wr_en), .din(din),
    .full(full), .empty(empty), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick), .overflow(overflow));

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .STOP_TICKS(32)) dut32 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .wr_en(wr_en2), .din(din2),
    .full(full2), .empty(empty2), .tx(tx2), .tx_busy(tx_busy2),
    .tx_done_tick(tx_done_tick2), .overflow(overflow2));

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    tick_cnt  = (tick_cnt + 1) % 4;
    baud_tick = (tick_cnt == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    if (!m_busy)                 return 1'b1;
    if (m_ticks < 16)            return 1'b0;
    if (m_ticks < 16 * (1 + 8))  return m_byte[(m_ticks - 16) / 16];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_ticks = 0; m_done = 0; m_ovf = 0;
    end else begin
      pop_now  = !m_busy && (m_q.size() > 0);
      full_pre = (m_q.size() == DEPTH);
      m_done = 0; m_ovf = 0;
      if (m_busy && baud_tick) begin
        m_ticks++;
        if (m_ticks == FRAME) begin m_busy = 0; m_done = 1; end
      end
      if (pop_now) begin m_byte = m_q.pop_front(); m_busy = 1; m_ticks = 0; end
      if (wr_en) begin
        if (full_pre) m_ovf = 1;
        else          m_q.push_back(din);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("cmp_tx", tx, exp_tx());
      chk("cmp_busy", tx_busy, m_busy);
      chk("cmp_done", tx_done_tick, m_done);
      chk("cmp_ovf", overflow, m_ovf);
      chk("cmp_full", full, m_q.size() == DEPTH);
      chk("cmp_empty", empty, m_q.size() == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_done_tick)  done_cnt++;
    if (tx_done_tick2) done2_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (!(empty && !tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'b0, empty && !tx_busy}, 32'd1);
    step();
  endtask

  // Write one byte into an idle transmitter and sample each bit near its centre (tick every 4 clks).
  task automatic send_and_check(input logic [7:0] b);
    wr_en = 1'b1; din = b;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("lat_empty", empty, 0);
    chk("lat_tx_idle", tx, 1);
    @(negedge clk);
    chk("lat_tx_start", tx, 0);
    chk("lat_busy", tx_busy, 1);
    repeat (94) @(negedge clk);
    chk("bit0", tx, b[0]);
    for (int i = 1; i < 8; i++) begin
      repeat (64) @(negedge clk);
      chk($sformatf("bit%0d", i), tx, b[i]);
    end
    repeat (64) @(negedge clk);
    chk("stop_bit", tx, 1);
    wait_idle(200);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_tx32", tx2, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // single byte 0xA5
    d0 = done_cnt;
    send_and_check(8'hA5);
    chk("a5_dones", done_cnt - d0, 1);
    chk("a5_empty", empty, 1);
    chk("a5_busy", tx_busy, 0);

    // back-to-back 0x00, 0xFF, 0x3C
    d0 = done_cnt;
    wr_en = 1'b1; din = 8'h00; step();
    din = 8'hFF; step();
    din = 8'h3C; step();
    wr_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_done_tick && n < 1000);
    chk("b2b_done_seen", tx_done_tick, 1);
    chk("gap_tx", tx, 1);
    chk("gap_busy", tx_busy, 0);
    @(negedge clk);
    chk("gap_next_tx", tx, 0);
    chk("gap_next_busy", tx_busy, 1);
    wait_idle(2000);
    chk("b2b_dones", done_cnt - d0, 3);

    // overflow: 6 writes into idle line
    d0 = done_cnt;
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; din = 8'(i);
      @(negedge clk);
      if (i == 5) chk("ovf_not_full_yet", full, 0);
      if (i == 6) chk("ovf_full", full, 1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_pulse", overflow, 1);
    @(negedge clk);
    chk("ovf_pulse_end", overflow, 0);
    wait_idle(4000);
    chk("ovf_dones", done_cnt - d0, 5);

    // reset in the middle of a frame with two bytes queued
    wr_en = 1'b1; din = 8'h11; step();
    din = 8'h22; step();
    din = 8'h33; step();
    wr_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 20);
    chk("mid_started", tx, 0);
    repeat (285) @(negedge clk);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_done", tx_done_tick, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) step();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_tx_idle", tx, 1);
    send_and_check(8'h5A);
    chk("mid_5a_done", done_cnt - d0, 1);

    // two stop bits on the second instance
    d0 = done2_cnt;
    wr_en2 = 1'b1; din2 = 8'h81; step();
    wr_en2 = 1'b0;
    seen = 0; tot = 0; ones = 0; zeros = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (tx_busy2) begin
        seen = 1;
        if (baud_tick) begin
          tot++;
          if (tx2) ones++;
          else     zeros++;
        end
      end else if (seen) begin
        break;
      end
    end
    chk("s32_frame_ticks", tot, 176);
    chk("s32_high_ticks", ones, 64);
    chk("s32_low_ticks", zeros, 112);
    step();
    chk("s32_dones", done2_cnt - d0, 1);
    chk("s32_tx_idle", tx2, 1);
    chk("s32_empty", empty2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
